// File: rtl/dmem_pkg.sv
// Shared types and helpers for the memory-stage data-memory responder.
package dmem_pkg;

   localparam int unsigned DMEM_BE_W   = 4;
   localparam int unsigned DMEM_DATA_W = 32;

   typedef enum logic [1:0] {DMEM_IDLE, DMEM_BUSY, DMEM_RESP} dmem_state_e;

   typedef struct packed {
      logic                   we;
      logic [31:0]            addr;
      logic [DMEM_DATA_W-1:0] wdata;
      logic [DMEM_BE_W-1:0]   be;
   } dmem_req_t;

   // Misaligned, or word index beyond the array; the full addr[31:2] is compared so nothing wraps.
   function automatic logic dmem_addr_err(input logic [31:0] addr, input int unsigned depth_words);
      return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words);
   endfunction

endpackage

// File: rtl/dmem_word_array.sv
// Synchronous single-port word storage with per-byte write enables and a registered read port.
module dmem_word_array
   import dmem_pkg::*;
#(
   parameter  int unsigned DEPTH_WORDS = 1024,
   localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
   input  logic                   clk,
   input  logic                   en,
   input  logic                   we,
   input  logic [AW-1:0]          addr,
   input  logic [DMEM_DATA_W-1:0] wdata,
   input  logic [DMEM_BE_W-1:0]   be,
   output logic [DMEM_DATA_W-1:0] rdata
);

   logic [DMEM_DATA_W-1:0] mem [DEPTH_WORDS];

   // NOTE: storage and its read register have no reset, so the array maps onto plain RAM macros.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int b = 0; b < int'(DMEM_BE_W); b++) begin
               if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, fixed-latency response out, error flagging.
// Optional DMEM_BACK2BACK_EN lets a new request be accepted on the response handshake cycle.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic                   req_we_i,
   input  logic [31:0]            req_addr_i,
   input  logic [DMEM_DATA_W-1:0] req_wdata_i,
   input  logic [DMEM_BE_W-1:0]   req_be_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [DMEM_DATA_W-1:0] rsp_rdata_o,
   output logic                   rsp_err_o
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   dmem_req_t              req;
   logic                   req_err;
   dmem_state_e            state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   we_q, err_q;
   logic [AW-1:0]          idx_q;
   logic                   accept, wr_en, rd_en;
   logic [DMEM_DATA_W-1:0] arr_rdata;

   assign req     = '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i, be: req_be_i};
   assign req_err = dmem_addr_err(req.addr, DEPTH_WORDS);

   // NOTE: every output of this block is given a default first so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_ready_o = 1'b0;
      accept      = 1'b0;
      rd_en       = 1'b0;
      unique case (state_q)
         DMEM_IDLE: begin
            req_ready_o = 1'b1;
            accept      = req_valid_i;
         end
         DMEM_BUSY: begin
            if (cnt_q == 4'd0) begin
               state_d = DMEM_RESP;
               rd_en   = ~we_q & ~err_q;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DMEM_RESP: begin
`ifdef DMEM_BACK2BACK_EN
            req_ready_o = rsp_ready_i;
            accept      = req_valid_i & rsp_ready_i;
`endif
            if (rsp_ready_i) state_d = DMEM_IDLE;
         end
         default: state_d = DMEM_IDLE;
      endcase
      if (accept) begin
         state_d = DMEM_BUSY;
         cnt_d   = 4'(LATENCY - 1);
      end
   end

   // Stores commit on the accept edge; loads read on the edge that enters RESP. They never coincide.
   assign wr_en = accept & req.we & ~req_err;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DMEM_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            we_q  <= req.we;
            err_q <= req_err;
            idx_q <= req.addr[2 +: AW];
         end
      end
   end

   dmem_word_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
      .clk   (clk),
      .en    (wr_en | rd_en),
      .we    (wr_en),
      .addr  (accept ? req.addr[2 +: AW] : idx_q),
      .wdata (req.wdata),
      .be    (req.be),
      .rdata (arr_rdata)
   );

   // Response fields are gated by state, so they clear on the handshake and read 0 out of reset.
   assign rsp_valid_o = (state_q == DMEM_RESP);
   assign rsp_err_o   = rsp_valid_o & err_q;
   assign rsp_rdata_o = (rsp_valid_o & ~we_q & ~err_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=2, DEPTH_WORDS=1024).
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_we_i    (req_we),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .req_be_i    (req_be),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      req_valid = 1'b1;
      for (int i = 0; i < 20 && !req_ready; i++) step();
      check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
      step();
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         step();
         lat++;
      end
   endtask

   task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic [31:0] exp_rdata, input logic exp_err);
      int lat;
      send(we, addr, wdata, be);
      wait_rsp(lat);
      check({tag, "_latency"}, 32'(lat), 32'd2);
      check({tag, "_rdata"}, rsp_rdata, exp_rdata);
      check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check({tag, "_valid_clear"}, {31'd0, rsp_valid}, 32'd0);
   endtask

   initial begin
      int lat;
      int acc[$];
      int period;

      // Reset state
      repeat (2) step();
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      check("rst_err", {31'd0, rsp_err}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      step();

      // 1: full-word store then load
      txn("t1_store", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
      txn("t1_load", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

      // 2: byte-masked store over a preloaded word (lanes 0 and 2), then a be=0 no-op store
      txn("t2_pre", 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0);
      txn("t2_mask", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
      txn("t2_load", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
      txn("t2_noop", 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
      txn("t2_reload", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);

      // 3: misaligned load, out-of-range store (index 1024 would alias word 0 if it wrapped)
      txn("t3_pre0", 1'b1, 32'h0, 32'h01234567, 4'hF, 32'h0, 1'b0);
      txn("t3_misaligned", 1'b0, 32'h22, 32'h0, 4'h0, 32'h0, 1'b1);
      txn("t3_range", 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1);
      txn("t3_reload0", 1'b0, 32'h0, 32'h0, 4'h0, 32'h01234567, 1'b0);
      txn("t3_mis_store", 1'b1, 32'h21, 32'h55555555, 4'hF, 32'h0, 1'b1);
      txn("t3_reload20", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);

      // 4: response held with rsp_ready low; a competing store must be ignored
      send(1'b0, 32'h10, 32'h0, 4'h0);
      wait_rsp(lat);
      check("t4_latency", 32'(lat), 32'd2);
      req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0BAD0BAD; req_be = 4'hF; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("t4_hold_valid", {31'd0, rsp_valid}, 32'd1);
         check("t4_hold_rdata", rsp_rdata, 32'hDEADBEEF);
         check("t4_hold_err", {31'd0, rsp_err}, 32'd0);
         check("t4_hold_ready", {31'd0, req_ready}, 32'd0);
         step();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check("t4_clear_valid", {31'd0, rsp_valid}, 32'd0);
      check("t4_clear_rdata", rsp_rdata, 32'd0);
      txn("t4_reload", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

      // 5: reset while BUSY; the committed store survives
      send(1'b1, 32'h30, 32'h5A5AA5A5, 4'hF);
      rst_n = 1'b0;
      #1;
      check("t5_rst_ready", {31'd0, req_ready}, 32'd1);
      check("t5_rst_valid", {31'd0, rsp_valid}, 32'd0);
      check("t5_rst_rdata", rsp_rdata, 32'd0);
      check("t5_rst_err", {31'd0, rsp_err}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      step();
      txn("t5_after", 1'b0, 32'h30, 32'h0, 4'h0, 32'h5A5AA5A5, 1'b0);

      // 6: continuous requests with rsp_ready high
`ifdef DMEM_BACK2BACK_EN
      period = 3;
`else
      period = 4;
`endif
      req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0; req_valid = 1'b1; rsp_ready = 1'b1;
      for (int c = 0; c < 24; c++) begin
         if (req_ready) acc.push_back(c);
         step();
      end
      req_valid = 1'b0;
      repeat (6) step();
      rsp_ready = 1'b0;
      check("t6_accept_count", 32'(acc.size() >= 5), 32'd1);
      for (int i = 1; i < acc.size() && i < 5; i++)
         check("t6_period", 32'(acc[i] - acc[i-1]), 32'(period));
      check("t6_idle_ready", {31'd0, req_ready}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
